// File: rtl/fetch_stage_unit_pkg.sv
// Shared constants and next-PC select encoding for the instruction-fetch stage.
package fetch_stage_unit_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned JUMP_INDEX_WIDTH = 26;
  localparam int unsigned PERF_WIDTH       = 32;

  localparam logic [DEF_DATA_WIDTH-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_BRANCH = 2'd1,
    PCSEL_JUMP   = 2'd2,
    PCSEL_JR     = 2'd3
  } pcsel_e;

  // Highest-priority redirect wins: JR, then J/JAL, then taken branch.
  function automatic pcsel_e pcsel_decode(input logic jr, input logic j, input logic br);
    if (jr) return PCSEL_JR;
    if (j)  return PCSEL_JUMP;
    if (br) return PCSEL_BRANCH;
    return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Loadable register with asynchronous active-high reset; used for the PC and IF/ID fields.
module pc_register #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= RESET_VALUE;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_stage_unit.sv
// MIPS instruction-fetch stage: PC, next-PC selection and IF/ID pipeline register.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating fetch/stall/flush counters.
module fetch_stage_unit
  import fetch_stage_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEF_RESET_PC),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEF_NOP_WORD)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Stall,
  input  logic                        Flush,
  input  logic                        BranchTaken,
  input  logic [DATA_WIDTH-1:0]       BranchTarget,
  input  logic                        Jump,
  input  logic [JUMP_INDEX_WIDTH-1:0] JumpTarget,
  input  logic                        JumpReg,
  input  logic [DATA_WIDTH-1:0]       JumpRegAddr,
  input  logic [DATA_WIDTH-1:0]       InstructionIn,
  output logic [DATA_WIDTH-1:0]       PCOut,
  output logic [DATA_WIDTH-1:0]       IFID_Instruction,
  output logic [DATA_WIDTH-1:0]       IFID_PCPlus4,
  output logic                        IFID_Valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH-1:0]       FetchCount,
  output logic [PERF_WIDTH-1:0]       StallCount,
  output logic [PERF_WIDTH-1:0]       FlushCount
`endif
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  pcsel_e                pcsel;
  logic                  redirect;
  logic                  pc_load;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  ifid_load;
  logic [DATA_WIDTH-1:0] ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pcplus4_d;
  logic                  ifid_valid_d;

  assign pc_plus4    = PCOut + DATA_WIDTH'(4);
  // Pseudo-direct target uses the region bits of the jump's own PC+4 held in IF/ID.
  assign jump_target = DATA_WIDTH'({IFID_PCPlus4[DATA_WIDTH-1 -: 4], JumpTarget, 2'b00});

  // Next-PC selection; a redirect overrides a stall for the PC.
  always_comb begin
    pcsel   = pcsel_decode(JumpReg, Jump, BranchTaken);
    pc_next = pc_plus4;
    case (pcsel)
      PCSEL_JR:     pc_next = JumpRegAddr & ALIGN_MASK;
      PCSEL_JUMP:   pc_next = jump_target;
      PCSEL_BRANCH: pc_next = BranchTarget & ALIGN_MASK;
      default:      pc_next = pc_plus4;
    endcase
    redirect = (pcsel != PCSEL_SEQ);
    pc_load  = redirect | ~Stall;
  end

  // IF/ID update; flush inserts a bubble even while stalled.
  always_comb begin
    ifid_load      = Flush | ~Stall;
    ifid_instr_d   = InstructionIn;
    ifid_pcplus4_d = pc_plus4;
    ifid_valid_d   = 1'b1;
    if (Flush) begin
      ifid_instr_d   = NOP_WORD;
      ifid_pcplus4_d = '0;
      ifid_valid_d   = 1'b0;
    end
  end

  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .load(pc_load), .d(pc_next), .q(PCOut)
  );

  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(NOP_WORD)) u_ifid_instr (
    .clk(clk), .reset(reset), .load(ifid_load), .d(ifid_instr_d), .q(IFID_Instruction)
  );

  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_ifid_pcplus4 (
    .clk(clk), .reset(reset), .load(ifid_load), .d(ifid_pcplus4_d), .q(IFID_PCPlus4)
  );

  pc_register #(.DATA_WIDTH(1), .RESET_VALUE(1'b0)) u_ifid_valid (
    .clk(clk), .reset(reset), .load(ifid_load), .d(ifid_valid_d), .q(IFID_Valid)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = ~Stall & ~Flush;
  assign stall_evt = Stall & ~Flush;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FetchCount <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (fetch_evt && (FetchCount != '1)) FetchCount <= FetchCount + PERF_WIDTH'(1);
      if (stall_evt && (StallCount != '1)) StallCount <= StallCount + PERF_WIDTH'(1);
      if (Flush && (FlushCount != '1))     FlushCount <= FlushCount + PERF_WIDTH'(1);
    end
  end
`endif

endmodule
